// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
// Holds HI/LO, runs MULT*/DIV*/MTxx and raises the MD stall request for the hazard unit.
module mult_div_unit #(
    parameter int MUL_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start_E,
    input  logic [2:0]  MDOp_E,
    input  logic [31:0] SrcA_E,
    input  logic [31:0] SrcB_E,
    input  logic        MDUse_D,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        MDStall
);
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W = (MUL_CYCLES > DIV_CYCLES) ? $clog2(MUL_CYCLES) : $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      prod_q, prod_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        is_mul, is_div, op_signed, accept;
    logic        a_neg, b_neg;
    logic [63:0] mul_a, mul_b;
    logic [32:0] shifted;
    logic        fits;

    assign is_mul    = (MDOp_E == 3'b000) || (MDOp_E == 3'b001);
    assign is_div    = (MDOp_E == 3'b010) || (MDOp_E == 3'b011);
    assign op_signed = ~MDOp_E[0];
    assign accept    = Start_E && (state_q == S_IDLE);
    assign a_neg     = op_signed & SrcA_E[31];
    assign b_neg     = op_signed & SrcB_E[31];
    assign mul_a     = {{32{a_neg}}, SrcA_E};
    assign mul_b     = {{32{b_neg}}, SrcB_E};

    // One restoring step: the dividend MSB enters the partial remainder from quo_q.
    assign shifted = {rem_q, quo_q[31]};
    assign fits    = shifted >= {1'b0, dvs_q};

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && is_mul)      state_d = S_MUL;
                else if (accept && is_div) state_d = S_DIV;
            end
            S_MUL:   if (cnt_q == '0) state_d = S_IDLE;
            S_DIV:   if (cnt_q == '0) state_d = S_FIX;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        prod_d = prod_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        negq_d = negq_q;
        negr_d = negr_q;
        dz_d   = dz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    prod_d = mul_a * mul_b;
                    cnt_d  = MUL_LAST;
                end else if (accept && is_div) begin
                    quo_d  = a_neg ? -SrcA_E : SrcA_E;
                    dvs_d  = b_neg ? -SrcB_E : SrcB_E;
                    rem_d  = '0;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    dz_d   = (SrcB_E == '0);
                    cnt_d  = DIV_LAST;
                end else if (accept && MDOp_E == 3'b100) begin
                    hi_d = SrcA_E;
                end else if (accept && MDOp_E == 3'b101) begin
                    lo_d = SrcA_E;
                end
            end
            S_MUL: begin
                if (cnt_q == '0) {hi_d, lo_d} = prod_q;
                else             cnt_d = cnt_q - 1'b1;
            end
            S_DIV: begin
                rem_d = fits ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];
                quo_d = {quo_q[30:0], fits};
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            default: begin
                // Divide by zero reports an all-ones quotient regardless of operand signs.
                lo_d = dz_q ? '1 : (negq_q ? -quo_q : quo_q);
                hi_d = negr_q ? -rem_q : rem_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            prod_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            dz_q   <= dz_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    always_comb begin
        HI      = hi_q;
        LO      = lo_q;
        Busy    = (state_q != S_IDLE);
        MDStall = MDUse_D && (Busy || (Start_E && (is_mul || is_div)));
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares whenever Busy falls.
module tb_mult_div_unit;
    localparam int MULC = 5;

    logic        clk = 1'b0;
    logic        rst_n, Start_E, Start1, MDUse_D;
    logic [2:0]  MDOp_E;
    logic [31:0] SrcA_E, SrcB_E;
    logic [31:0] HI, LO, HI1, LO1;
    logic        Busy, MDStall, Busy1, MDStall1;

    mult_div_unit #(.MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst_n(rst_n), .Start_E(Start_E), .MDOp_E(MDOp_E),
        .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .MDUse_D(MDUse_D),
        .HI(HI), .LO(LO), .Busy(Busy), .MDStall(MDStall)
    );

    mult_div_unit #(.MUL_CYCLES(1)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .Start_E(Start1), .MDOp_E(MDOp_E),
        .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .MDUse_D(MDUse_D),
        .HI(HI1), .LO(LO1), .Busy(Busy1), .MDStall(MDStall1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        logic [2:0]  op;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: plain 64-bit arithmetic, truncating division.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, sp, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.op = op;
        e.cycles = (op[1]) ? 33 : MULC;
        e.hi = '0;
        e.lo = '0;
        case (op)
            3'b000: begin sp = sa * sb; e.hi = sp[63:32]; e.lo = sp[31:0]; end
            3'b001: begin up = {32'b0, a} * {32'b0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            3'b010: begin
                if (b == 0) begin e.lo = '1; e.hi = a; end
                else begin q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0]; end
            end
            default: begin
                if (b == 0) begin e.lo = '1; e.hi = a; end
                else begin e.lo = a / b; e.hi = a % b; end
            end
        endcase
        return e;
    endfunction

    initial begin : monitor
        int   bcnt = 0;
        bit   prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
                prev = 0;
            end else if (Busy) begin
                bcnt++;
                prev = 1;
            end else if (prev) begin
                prev = 0;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_completion", 32'(sb_q.size()), 1);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("sb_hi op%0d", e.op), HI, e.hi);
                    check($sformatf("sb_lo op%0d", e.op), LO, e.lo);
                    check($sformatf("sb_busy_cycles op%0d", e.op), 32'(bcnt), 32'(e.cycles));
                end
                bcnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 100) begin
            tick();
            n++;
        end
        if (Busy) check("idle_timeout", 32'(Busy), 0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_idle();
        Start_E = 1'b1;
        MDOp_E  = op;
        SrcA_E  = a;
        SrcB_E  = b;
        if (op <= 3'b011) begin
            e = model(op, a, b);
            sb_q.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end else if (op == 3'b100) begin
            m_hi = a;
        end else if (op == 3'b101) begin
            m_lo = a;
        end
        tick();
        Start_E = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(($urandom_range(0, 1) == 0) ? $urandom_range(1, 20) : -$urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        logic [2:0]  op;
        logic [31:0] a, b;
        exp_t        e;
        rst_n = 1'b0; Start_E = 1'b0; Start1 = 1'b0; MDUse_D = 1'b0;
        MDOp_E = 3'b000; SrcA_E = '0; SrcB_E = '0;

        // Reset holds everything at zero even with a MULT presented.
        tick();
        Start_E = 1'b1; MDOp_E = 3'b000; SrcA_E = 3; SrcB_E = 4;
        @(negedge clk);
        check("rst_hi", HI, 0); check("rst_lo", LO, 0); check("rst_busy", 32'(Busy), 0);
        tick();
        Start_E = 1'b0;
        check("rst_busy_after_edge", 32'(Busy), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", 32'(Busy), 0); check("post_rst_lo", LO, 0);

        // Directed test-plan operations against literal results.
        issue(3'b000, 32'hFFFF_FFFD, 7); wait_idle();
        check("mult_hi", HI, 32'hFFFF_FFFF); check("mult_lo", LO, 32'hFFFF_FFEB);
        issue(3'b001, 32'hFFFF_FFFD, 7); wait_idle();
        check("multu_hi", HI, 32'h0000_0006); check("multu_lo", LO, 32'hFFFF_FFEB);
        issue(3'b010, 32'hFFFF_FFF9, 2); wait_idle();
        check("div_lo", LO, 32'hFFFF_FFFD); check("div_hi", HI, 32'hFFFF_FFFF);
        issue(3'b011, 100, 7); wait_idle();
        check("divu_lo", LO, 14); check("divu_hi", HI, 2);
        issue(3'b011, 5, 0); wait_idle();
        check("divu0_lo", LO, 32'hFFFF_FFFF); check("divu0_hi", HI, 5);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        check("divovf_lo", LO, 32'h8000_0000); check("divovf_hi", HI, 0);

        // Stall window around a MULT with MFLO waiting in D.
        MDUse_D = 1'b1;
        Start_E = 1'b1; MDOp_E = 3'b000; SrcA_E = 32'd123456; SrcB_E = 32'hFFFF_FF00;
        e = model(3'b000, SrcA_E, SrcB_E);
        sb_q.push_back(e); m_hi = e.hi; m_lo = e.lo;
        @(negedge clk);
        check("stall_start", 32'(MDStall), 1);
        tick();
        Start_E = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (Busy) begin
                check("stall_busy", 32'(MDStall), 1);
            end else begin
                check("stall_fall", 32'(MDStall), 0);
                check("stall_fall_lo", LO, e.lo);
                break;
            end
        end
        check("stall_window_ended", 32'(Busy), 0);

        // MTLO then MFLO: no stall, LO written after one edge.
        tick();
        Start_E = 1'b1; MDOp_E = 3'b101; SrcA_E = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mtlo_no_stall", 32'(MDStall), 0);
        tick();
        Start_E = 1'b0; m_lo = 32'hDEAD_BEEF;
        check("mtlo_lo", LO, 32'hDEAD_BEEF); check("mtlo_busy", 32'(Busy), 0);
        check("mtlo_no_stall_after", 32'(MDStall), 0);
        MDUse_D = 1'b0;
        issue(3'b100, 32'h1234_5678, 0);
        check("mthi_hi", HI, 32'h1234_5678); check("mthi_lo_kept", LO, 32'hDEAD_BEEF);

        // Start_E while busy must not disturb the running divide.
        issue(3'b011, 1000, 3);
        repeat (5) tick();
        Start_E = 1'b1; MDOp_E = 3'b101; SrcA_E = 32'hAAAA_AAAA;
        tick();
        MDOp_E = 3'b000; SrcA_E = 9; SrcB_E = 9;
        tick();
        Start_E = 1'b0;
        wait_idle();
        check("busy_ignore_lo", LO, 333); check("busy_ignore_hi", HI, 1);

        // MUL_CYCLES=1 instance: Busy for exactly one cycle.
        MDOp_E = 3'b001; SrcA_E = 32'h0001_0000; SrcB_E = 32'h0001_0003;
        Start1 = 1'b1;
        tick();
        Start1 = 1'b0;
        check("m1_busy_on", 32'(Busy1), 1);
        tick();
        check("m1_busy_off", 32'(Busy1), 0);
        check("m1_hi", HI1, 32'h0000_0001); check("m1_lo", LO1, 32'h0003_0000);

        // Randomized mix including MTxx and unused opcodes.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b);
            wait_idle();
            if (op >= 3'b110) check("unused_op_busy", 32'(Busy), 0);
            check($sformatf("arch_hi #%0d", i), HI, m_hi);
            check($sformatf("arch_lo #%0d", i), LO, m_lo);
        end

        // Asynchronous reset in cycle 10 of a DIV.
        issue(3'b010, 32'h1234_5678, 32'h77);
        repeat (9) tick();
        check("pre_abort_busy", 32'(Busy), 1);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(Busy), 0); check("abort_hi", HI, 0); check("abort_lo", LO, 0);
        void'(sb_q.pop_back());
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst_n = 1'b1;
        tick();
        issue(3'b001, 2, 3); wait_idle();
        check("after_abort_lo", LO, 6); check("after_abort_hi", HI, 0);

        repeat (2) tick();
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the 5-stage MIPS pipeline; sits in the E stage beside the ALU.
- Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, and holds the HI/LO architectural registers.
- Generates the MD stall request that the hazard unit ORs into Stall_F/Stall_D/Flush_E while a later instruction needs HI/LO or the unit.

Parameters:
- MUL_CYCLES, 5, cycles from MULT/MULTU acceptance to result valid in HI/LO (>=1).
- DIV_CYCLES, 32, shift-subtract iterations for DIV/DIVU (fixed at 32, one quotient bit per cycle).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Start_E  in  1  valid MD instruction in E this cycle (already qualified by Flush_E upstream).
- MDOp_E  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others = no-op.
- SrcA_E  in  32  rs operand (dividend / multiplicand / MTxx data), post-forwarding.
- SrcB_E  in  32  rt operand (divisor / multiplier).
- MDUse_D  in  1  instruction in D is MFHI/MFLO/MTHI/MTLO/MULT*/DIV*.
- HI  out  32  HI register.
- LO  out  32  LO register.
- Busy  out  1  multi-cycle operation in progress.
- MDStall  out  1  stall request to hazard unit.

Behaviour:
- Reset (async, rst_n=0): HI=0, LO=0, Busy=0, state IDLE, counter=0, internal remainder/quotient regs=0; MDStall follows its equation, so it is 0 unless MDUse_D=1 and Start_E=1.
- States: IDLE, MUL, DIV, FIX.
- IDLE: on Start_E with MULT/MULTU -> latch 64-bit product (signed or unsigned per op), counter=MUL_CYCLES-1, go MUL, Busy=1 next cycle.
- IDLE: on Start_E with DIV/DIVU -> latch |dividend|, |divisor| (raw for DIVU), quotient/result sign flags, counter=31, go DIV.
- IDLE: on Start_E with MTHI/MTLO -> HI (resp. LO) = SrcA_E at the next edge; stay IDLE; Busy stays 0.
- Start_E with an unused MDOp_E: ignored.
- Start_E while Busy=1: cannot occur (MDStall prevents it). If asserted anyway, it is ignored; the current operation is not disturbed.
- MUL: decrement counter each cycle; when counter==0, write {HI,LO}=product, go IDLE, Busy=0 the same edge. Total: Busy high for MUL_CYCLES cycles; HI/LO valid in the cycle Busy falls.
- MULT/MULTU with MUL_CYCLES=1: Busy high exactly 1 cycle.
- DIV: restoring division, one bit per cycle. Remainder shifts left, bringing in the dividend MSB; subtract the divisor if no borrow; the quotient bit is 1 if the subtraction succeeded. Decrement counter; at counter==0 go FIX.
- FIX (1 cycle): apply signs for DIV only.
  - quotient negated if dividend sign != divisor sign.
  - remainder takes the dividend's sign.
  - LO=quotient, HI=remainder.
  - go IDLE, Busy=0.
- DIV/DIVU total Busy time: 33 cycles.
- Divide by zero (SrcB_E==0): no trap; runs the full 33 cycles. Result: LO=32'hFFFFFFFF, HI=SrcA_E (unsigned dividend, sign-restored for DIV).
- DIV of 32'h80000000 by -1: LO=32'h80000000, HI=0 (natural wrap, no exception).
- MDStall = MDUse_D && (Busy || (Start_E && MDOp_E is MULT/MULTU/DIV/DIVU)). Combinational; it deasserts in the same cycle Busy falls, when HI/LO already hold the result.
- MTHI/MTLO in E followed by MFHI in D: no stall; MFHI reads in E after the write edge.
- HI/LO change only at operation completion or MTxx; intermediate state is never visible on HI/LO.
- rst_n low mid-operation aborts immediately to the reset values above.

Test Plan:
- Reset: hold rst_n=0, pulse Start_E MULT 3*4 -> HI=0, LO=0, Busy=0 throughout; release, no activity.
- MULT -3 (32'hFFFFFFFD) * 7 with MUL_CYCLES=5 -> Busy high exactly 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; MULTU same operands -> HI=32'h00000006, LO=32'hFFFFFFEB.
- DIV -7 / 2 -> Busy 33 cycles, LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> LO=32'hFFFFFFFF, HI=5 after 33 cycles; DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- Stall: MULT in E with MDUse_D=1 (MFLO in D) -> MDStall=1 from the Start_E cycle through the last Busy cycle, 0 in the cycle Busy falls; LO correct in that cycle. MTLO 32'hDEADBEEF followed by MFLO -> MDStall never asserts, LO=32'hDEADBEEF after one edge.
- Async reset mid-DIV (cycle 10 of 33): rst_n low between clock edges -> Busy, HI, LO go to 0 immediately; after release, a new MULTU 2*3 completes normally with LO=6.
